// File: rtl/fc_mac_engine.sv
// fc_mac_engine
// Time-multiplexed fully connected layer for the keyword-spotting classifier
// head. One packed input vector is captured per transaction. OUT_LEN neurons
// are then evaluated one after another on a single signed MAC, with weights
// and biases fetched from an external synchronous memory. Each neuron result
// leaves over a ready/valid port, with optional ReLU and saturation to DATA_W.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     input vector handshake
//   in_data               packed vector, element 0 in bits [DATA_W-1:0]
//   w_rd                  weight/bias read strobe
//   w_addr                neuron*IN_LEN + element
//   b_addr                current neuron
//   w_data, b_data        read data, valid the cycle after w_rd
//   out_valid/out_ready   result handshake
//   out_data              saturated neuron result
//   out_index             neuron number of out_data
//   out_last              high with the result of the final neuron
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// MAC   | one weight read per element, products accumulate one cycle later
// DRAIN | no read; absorbs the last product and registers the result
// EMIT  | result presented, held until out_ready
module fc_mac_engine #(
  parameter int IN_LEN     = 32,
  parameter int OUT_LEN    = 8,
  parameter int DATA_W     = 16,
  parameter int WEIGHT_W   = 8,
  parameter int FRAC_SHIFT = 7,
  parameter int ACC_W      = 40,
  parameter int RELU       = 1,
  localparam int AW = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
  localparam int NW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1,
  localparam int EW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_LEN*DATA_W-1:0] in_data,
  output logic                     w_rd,
  output logic [AW-1:0]            w_addr,
  output logic [NW-1:0]            b_addr,
  input  logic [WEIGHT_W-1:0]      w_data,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [NW-1:0]            out_index,
  output logic                     out_last
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, EMIT} state_t;

  localparam logic [EW-1:0] ELEM_LAST = EW'(IN_LEN - 1);
  localparam logic [NW-1:0] NEUR_LAST = NW'(OUT_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [IN_LEN*DATA_W-1:0]        x_reg;
  logic [NW-1:0]                   neuron;
  logic [EW-1:0]                   elem;
  logic [EW-1:0]                   elem_d;
  logic                            rd_d;
  logic                            first_d;
  logic signed [ACC_W-1:0]         acc;
  logic signed [ACC_W-1:0]         acc_nxt;
  logic signed [DATA_W-1:0]        x_arr [IN_LEN];
  logic signed [DATA_W+WEIGHT_W-1:0] prod;
  logic signed [ACC_W-1:0]         res;
  logic [DATA_W-1:0]               res_sat;
  logic                            last;

  assign last = (neuron == NEUR_LAST);

  always_comb begin
    for (int i = 0; i < IN_LEN; i++) x_arr[i] = x_reg[i*DATA_W +: DATA_W];
  end

  // Memory data for the read issued last cycle arrives now; elem_d/first_d
  // follow the read by one cycle so the product lines up with its operand.
  always_comb begin
    prod    = x_arr[elem_d] * $signed(w_data);
    acc_nxt = acc;
    if (rd_d) begin
      if (first_d) acc_nxt = (ACC_W'($signed(b_data)) <<< FRAC_SHIFT) + ACC_W'(prod);
      else         acc_nxt = acc + ACC_W'(prod);
    end
  end

  always_comb begin
    res = acc_nxt >>> FRAC_SHIFT;
    if (RELU != 0 && res < 0) res = '0;
    if (res > SAT_MAX)      res_sat = SAT_MAX[DATA_W-1:0];
    else if (res < SAT_MIN) res_sat = SAT_MIN[DATA_W-1:0];
    else                    res_sat = res[DATA_W-1:0];
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = MAC;
      MAC:   if (elem == ELEM_LAST) state_nxt = DRAIN;
      DRAIN: state_nxt = EMIT;
      EMIT:  if (out_ready) state_nxt = last ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready  = (state == IDLE);
    w_rd      = (state == MAC);
    out_valid = (state == EMIT);
    out_last  = (state == EMIT) && last;
    out_index = neuron;
    b_addr    = neuron;
    w_addr    = AW'(neuron * IN_LEN + elem);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg    <= '0;
      neuron   <= '0;
      elem     <= '0;
      elem_d   <= '0;
      rd_d     <= 1'b0;
      first_d  <= 1'b0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      rd_d    <= w_rd;
      first_d <= (elem == '0);
      elem_d  <= elem;
      acc     <= acc_nxt;
      case (state)
        IDLE: if (in_valid) begin
          x_reg  <= in_data;
          neuron <= '0;
          elem   <= '0;
        end
        MAC:   elem <= (elem == ELEM_LAST) ? '0 : elem + 1'b1;
        DRAIN: out_data <= res_sat;
        EMIT: if (out_ready) begin
          if (last) neuron <= '0;
          else      neuron <= neuron + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
module tb_fc_mac_engine;
  localparam int IL = 4;
  localparam int OL = 2;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int NV = 14;

  typedef struct packed {
    logic [IL-1:0][DW-1:0]    x;
    logic [IL*OL-1:0][WW-1:0] w;
    logic [OL-1:0][DW-1:0]    b;
    logic                     stall;
    logic [OL-1:0][DW-1:0]    exp_relu;
    logic [OL-1:0][DW-1:0]    exp_lin;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready;
  logic [IL*DW-1:0] in_data;

  logic          in_ready_r, w_rd_r, out_valid_r, out_last_r;
  logic [2:0]    w_addr_r;
  logic [0:0]    b_addr_r, out_index_r;
  logic [WW-1:0] w_data_r = '0;
  logic [DW-1:0] b_data_r = '0;
  logic [DW-1:0] out_data_r;

  logic          in_ready_l, w_rd_l, out_valid_l, out_last_l;
  logic [2:0]    w_addr_l;
  logic [0:0]    b_addr_l, out_index_l;
  logic [WW-1:0] w_data_l = '0;
  logic [DW-1:0] b_data_l = '0;
  logic [DW-1:0] out_data_l;

  fc_mac_engine #(.IN_LEN(IL), .OUT_LEN(OL), .RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .w_rd(w_rd_r), .w_addr(w_addr_r), .b_addr(b_addr_r),
    .w_data(w_data_r), .b_data(b_data_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_data_r), .out_index(out_index_r),
    .out_last(out_last_r));

  fc_mac_engine #(.IN_LEN(IL), .OUT_LEN(OL), .RELU(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .w_rd(w_rd_l), .w_addr(w_addr_l), .b_addr(b_addr_l),
    .w_data(w_data_l), .b_data(b_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_data(out_data_l), .out_index(out_index_l),
    .out_last(out_last_l));

  logic [WW-1:0] wmem [IL*OL];
  logic [DW-1:0] bmem [OL];

  always @(posedge clk) begin
    if (w_rd_r) begin
      w_data_r <= wmem[w_addr_r];
      b_data_r <= bmem[b_addr_r];
    end
    if (w_rd_l) begin
      w_data_l <= wmem[w_addr_l];
      b_data_l <= bmem[b_addr_l];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int addr_q[$];
  int baddr_q[$];
  always @(negedge clk) begin
    if (w_rd_r) begin
      addr_q.push_back(int'(w_addr_r));
      baddr_q.push_back(int'(b_addr_r));
    end
  end

  int total = 0;
  int bad = 0;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: bias scaled by 2^7 plus the exact dot product, floor-divided
  // by 2^7, optional clamp at zero, then clipped to the 16-bit signed range.
  function automatic logic [DW-1:0] model(input vec_t v, input int n, input bit relu);
    longint acc;
    acc = longint'($signed(v.b[n])) * 128;
    for (int k = 0; k < IL; k++)
      acc += longint'($signed(v.x[k])) * longint'($signed(v.w[n*IL+k]));
    acc = acc >>> 7;
    if (relu && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[DW-1:0];
  endfunction

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < IL*OL; i++) wmem[i] = v.w[i];
    for (int i = 0; i < OL; i++) bmem[i] = v.b[i];
  endtask

  task automatic run_vec(input vec_t v, input bit chk_time);
    int t0;
    int waited;
    logic [DW-1:0] hd;
    logic [0:0] hi;
    logic hl;
    load_mem(v);
    out_ready = !v.stall;
    @(negedge clk);
    addr_q.delete();
    baddr_q.delete();
    chk("in_ready_idle", in_ready_r, 1);
    in_valid = 1'b1;
    in_data  = v.x;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    for (int n = 0; n < OL; n++) begin
      waited = 0;
      while (!out_valid_r && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (!out_valid_r) begin
        chk("out_valid_timeout", 0, 1);
        out_ready = 1'b1;
        return;
      end
      if (chk_time) chk("latency", cyc - t0, (n == 0) ? 5 : 11);
      chk("data_relu", out_data_r, v.exp_relu[n]);
      chk("data_lin", out_data_l, v.exp_lin[n]);
      chk("valid_lin", out_valid_l, 1);
      chk("index", out_index_r, n);
      chk("last", out_last_r, (n == OL-1));
      if (v.stall && n == 0) begin
        hd = out_data_r;
        hi = out_index_r;
        hl = out_last_r;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", out_valid_r, 1);
          chk("stall_data", out_data_r, hd);
          chk("stall_index", out_index_r, hi);
          chk("stall_last", out_last_r, hl);
          chk("stall_no_read", w_rd_r, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("in_ready_after", in_ready_r, 1);
    chk("valid_after", out_valid_r, 0);
    if (chk_time) chk("in_ready_time", cyc - t0, 12);
    chk("read_count", addr_q.size(), IL*OL);
    for (int i = 0; i < addr_q.size() && i < IL*OL; i++) begin
      chk("w_addr_seq", addr_q[i], i);
      chk("b_addr_seq", baddr_q[i], i / IL);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;

    // 0: reference vector; neuron 1 negative
    tbl[0].x = {16'd1024, 16'd768, 16'd512, 16'd256};
    tbl[0].w = {{4{8'hC0}}, {4{8'd64}}};
    tbl[0].b = '0;
    tbl[0].stall = 1'b0;
    tbl[0].exp_relu = {16'd0, 16'd1280};
    tbl[0].exp_lin  = {16'hFB00, 16'd1280};
    // 1: same with a 5-cycle stall on the first result
    tbl[1] = tbl[0];
    tbl[1].stall = 1'b1;
    // 2: positive saturation
    tbl[2].x = {4{16'h7FFF}};
    tbl[2].w = {8{8'd127}};
    tbl[2].b = '0;
    tbl[2].stall = 1'b0;
    tbl[2].exp_relu = {16'h7FFF, 16'h7FFF};
    tbl[2].exp_lin  = {16'h7FFF, 16'h7FFF};
    // 3: negative saturation
    tbl[3].x = {4{16'h7FFF}};
    tbl[3].w = {8{8'h80}};
    tbl[3].b = '0;
    tbl[3].stall = 1'b0;
    tbl[3].exp_relu = {16'h0000, 16'h0000};
    tbl[3].exp_lin  = {16'h8000, 16'h8000};
    // 4: bias only
    tbl[4].x = {16'd1024, 16'd768, 16'd512, 16'd256};
    tbl[4].w = '0;
    tbl[4].b = {16'hFF00, 16'd256};
    tbl[4].stall = 1'b0;
    tbl[4].exp_relu = {16'h0000, 16'd256};
    tbl[4].exp_lin  = {16'hFF00, 16'd256};
    for (int i = 5; i < NV; i++) begin
      for (int k = 0; k < IL; k++)
        tbl[i].x[k] = (i % 2 == 1) ? DW'($urandom) : DW'($urandom_range(0, 4095)) - 16'd2048;
      for (int k = 0; k < IL*OL; k++) tbl[i].w[k] = WW'($urandom);
      for (int k = 0; k < OL; k++) tbl[i].b[k] = DW'($urandom);
      tbl[i].stall = (i % 3 == 0);
      for (int n = 0; n < OL; n++) begin
        tbl[i].exp_relu[n] = model(tbl[i], n, 1'b1);
        tbl[i].exp_lin[n]  = model(tbl[i], n, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready_r, 1);
    chk("rst_out_valid", out_valid_r, 0);
    chk("rst_out_last", out_last_r, 0);
    chk("rst_w_rd", w_rd_r, 0);
    chk("rst_out_data", out_data_r, 0);
    chk("rst_out_index", out_index_r, 0);
    chk("rst_w_addr", w_addr_r, 0);
    chk("rst_b_addr", b_addr_r, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(tbl[i], (i == 0) || (i >= 2 && i <= 4));

    // abort a transaction with a one-cycle reset during MAC
    load_mem(tbl[2]);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = tbl[2].x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_mac_reading", w_rd_r, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready_r, 1);
    chk("abort_out_valid", out_valid_r, 0);
    chk("abort_w_rd", w_rd_r, 0);
    chk("abort_w_addr", w_addr_r, 0);
    chk("abort_lin_in_ready", in_ready_l, 1);
    rst_n = 1'b1;
    run_vec(tbl[0], 1'b1);
    run_vec(tbl[5], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
